// File: rtl/decode_issue_queue_if.sv
// Decode-to-backend handshake bundle for decode_issue_queue.
// The queue uses the slave view; the decode/backend environment uses the master view.
interface decode_issue_queue_if #(
    parameter int PKT_WIDTH = 256
);
    logic                 dec_valid_i;
    logic                 dec_ready_o;
    logic [PKT_WIDTH-1:0] dec_pkt_i;
    logic                 be_valid_o;
    logic                 be_ready_i;
    logic [PKT_WIDTH-1:0] be_pkt_o;

    modport slave (
        input  dec_valid_i, dec_pkt_i, be_ready_i,
        output dec_ready_o, be_valid_o, be_pkt_o
    );

    modport master (
        output dec_valid_i, dec_pkt_i, be_ready_i,
        input  dec_ready_o, be_valid_o, be_pkt_o
    );
endinterface

// File: rtl/decode_issue_queue.sv
// Circular FIFO of opaque decoded packets between decode and backend dispatch.
// Optional zero-latency empty-queue bypass: define DECODE_QUEUE_BYPASS_EN.
module decode_issue_queue #(
    parameter  int DEPTH     = 4,
    parameter  int PKT_WIDTH = 256,
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush_i,
    input  logic                 stall_i,
    decode_issue_queue_if.slave  q,
    output logic [CNT_WIDTH-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PKT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_WIDTH-1:0] count;
    logic                 full;
    logic                 empty;
    logic                 queued_valid;
    logic                 bypass;
    logic                 push;
    logic                 pop;

    // Full/empty come from the count only; pointers alias when full vs empty.
    assign full  = (count == CNT_WIDTH'(DEPTH));
    assign empty = (count == '0);

    assign queued_valid = ~empty & ~stall_i & ~flush_i;

`ifdef DECODE_QUEUE_BYPASS_EN
    assign bypass = empty & q.dec_valid_i & q.be_ready_i & ~stall_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign q.dec_ready_o = ~full & ~flush_i;
    assign q.be_valid_o  = queued_valid | bypass;
    assign q.be_pkt_o    = bypass ? q.dec_pkt_i : mem[head];
    assign count_o       = count;

    // A bypassed packet completes both handshakes without touching storage.
    assign push = q.dec_valid_i & q.dec_ready_o & ~bypass;
    assign pop  = queued_valid & q.be_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left unreset; validity is tracked by count,
    // so resetting the array would only add reset fan-out and block RAM mapping.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= q.dec_pkt_i;
    end
endmodule
